// File: rtl/onehot_rr_grant_arbiter_if.sv
// Request/grant bundle for onehot_rr_grant_arbiter.
//   master : request side (drives req, rr_mode, release_i; observes grant/status)
//   slave  : arbiter side (observes requests; drives grant/status)
// Signals:
//   req        N_REQ  request vector, bit k = requester k
//   rr_mode    1      0 = strict one-hot, 1 = round-robin
//   release_i  1      holder ends its grant
//   gnt_valid  1      grant active
//   gnt_code   GC_W   0 = no grant, k+1 = requester k granted
//   gnt_onehot N_REQ  one-hot grant vector
//   viol       1      multi-bit request pulse (strict mode)
//   viol_cnt   CNT_W  saturating violation count
//   timeout    1      forced-revoke pulse
interface onehot_rr_grant_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned GC_W = $clog2(N_REQ + 1);

  logic [N_REQ-1:0] req;
  logic             rr_mode;
  logic             release_i;
  logic             gnt_valid;
  logic [GC_W-1:0]  gnt_code;
  logic [N_REQ-1:0] gnt_onehot;
  logic             viol;
  logic [CNT_W-1:0] viol_cnt;
  logic             timeout;

  modport master (
    output req, rr_mode, release_i,
    input  gnt_valid, gnt_code, gnt_onehot, viol, viol_cnt, timeout
  );

  modport slave (
    input  req, rr_mode, release_i,
    output gnt_valid, gnt_code, gnt_onehot, viol, viol_cnt, timeout
  );
endinterface

// File: rtl/onehot_rr_grant_arbiter.sv
// Registered request arbiter with held-grant handshake.
//   Strict one-hot mode grants a single requester and flags multi-bit requests as violations;
//   round-robin mode arbitrates multi-bit requests fairly starting at a rotating pointer.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    onehot_rr_grant_arbiter_if.slave (requests in; grant, violation, timeout out)
// Optional feature: define ARB_HOLD_TIMEOUT_EN to force-revoke a grant held for MAX_HOLD cycles.
// Without it the grant is held indefinitely and timeout is tied to 0.
module onehot_rr_grant_arbiter #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  onehot_rr_grant_arbiter_if.slave bus
);
  localparam int unsigned GC_W  = $clog2(N_REQ + 1);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [GC_W-1:0]  gnt_code_q, gnt_code_d;
  logic [N_REQ-1:0] gnt_onehot_q, gnt_onehot_d;
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
`endif

  // Request decode: popcount + position of a set bit (strict), and the first set bit at or
  // above ptr with wrap-around (round-robin).
  logic [GC_W-1:0]  pop_cnt;
  logic [IDX_W-1:0] one_idx;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_hit;
  int unsigned      rr_pos;

  always_comb begin
    pop_cnt = '0;
    one_idx = '0;
    rr_idx  = '0;
    rr_hit  = 1'b0;
    rr_pos  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (bus.req[k]) begin
        pop_cnt = pop_cnt + GC_W'(1);
        one_idx = IDX_W'(k);
      end
      rr_pos = 32'(ptr_q) + k;
      if (rr_pos >= N_REQ) rr_pos = rr_pos - N_REQ;
      if (!rr_hit && bus.req[rr_pos]) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(rr_pos);
      end
    end
  end

  logic             do_grant;
  logic             do_exit;
  logic [IDX_W-1:0] sel_idx;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_code_d   = gnt_code_q;
    gnt_onehot_d = gnt_onehot_q;
    viol_d       = 1'b0;
    viol_cnt_d   = viol_cnt_q;
    do_grant     = 1'b0;
    do_exit      = 1'b0;
    sel_idx      = '0;
`ifdef ARB_HOLD_TIMEOUT_EN
    hold_d       = hold_q;
    timeout_d    = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (bus.req != '0) begin
          if (bus.rr_mode) begin
            do_grant = 1'b1;
            sel_idx  = rr_idx;
          end else if (pop_cnt == GC_W'(1)) begin
            do_grant = 1'b1;
            sel_idx  = one_idx;
          end else begin
            viol_d = 1'b1;
            if (viol_cnt_q != '1) viol_cnt_d = viol_cnt_q + CNT_W'(1);
          end
        end
      end
      StGrant: begin
        // Release beats timeout when both land in the same cycle.
        if (bus.release_i || !bus.req[idx_q]) begin
          do_exit = 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
        end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          do_exit   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_grant) begin
      state_d      = StGrant;
      idx_d        = sel_idx;
      gnt_valid_d  = 1'b1;
      gnt_code_d   = GC_W'(sel_idx) + GC_W'(1);
      gnt_onehot_d = N_REQ'(1) << sel_idx;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_d       = '0;
`endif
    end

    if (do_exit) begin
      state_d      = StIdle;
      gnt_valid_d  = 1'b0;
      gnt_code_d   = '0;
      gnt_onehot_d = '0;
      ptr_d        = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      ptr_q        <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_code_q   <= '0;
      gnt_onehot_q <= '0;
      viol_q       <= 1'b0;
      viol_cnt_q   <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_code_q   <= gnt_code_d;
      gnt_onehot_q <= gnt_onehot_d;
      viol_q       <= viol_d;
      viol_cnt_q   <= viol_cnt_d;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_q       <= hold_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_code   = gnt_code_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.viol       = viol_q;
  assign bus.viol_cnt   = viol_cnt_q;
`ifdef ARB_HOLD_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule
